// File: rtl/icache_sa_pkg.sv
// rtl/icache_sa_pkg.sv - shared defaults and state type for the set-associative instruction cache
package icache_sa_pkg;

  localparam int ICACHE_WAYS   = 2;
  localparam int ICACHE_SETS   = 16;
  localparam int ICACHE_LINE_W = 128;

  typedef enum logic [1:0] {
    IDLE,
    REFILL,
    FLUSH
  } icache_state_t;

endpackage

// File: rtl/icache_sa_if.sv
// rtl/icache_sa_if.sv - line refill bus between the instruction cache and instruction memory
interface icache_sa_if #(
  parameter int ADDR_W = 20,
  parameter int LINE_W = 128
);

  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rdy;
  logic [LINE_W-1:0] mem_data;

  modport master (output mem_req, output mem_addr, input mem_rdy, input mem_data);
  modport slave  (input mem_req, input mem_addr, output mem_rdy, output mem_data);

endinterface

// File: rtl/icache_sa_way.sv
// rtl/icache_sa_way.sv - one cache way: data, tag and valid arrays with lookup and fill/invalidate ports
module icache_way #(
  parameter int INST_W = 32,
  parameter int LINE_W = 128,
  parameter int SETS   = 16,
  parameter int TAG_W  = 12,
  localparam int IDX_W  = $clog2(SETS),
  localparam int WSEL_W = $clog2(LINE_W / INST_W)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [IDX_W-1:0]  rd_idx,
  input  logic [TAG_W-1:0]  rd_tag,
  input  logic [WSEL_W-1:0] rd_wsel,
  output logic              rd_valid,
  output logic              rd_hit,
  output logic [INST_W-1:0] rd_word,
  input  logic              fill,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [TAG_W-1:0]  wr_tag,
  input  logic [LINE_W-1:0] wr_line,
  input  logic              inv,
  input  logic [IDX_W-1:0]  inv_idx
);

  logic [SETS-1:0]   valid;
  logic [TAG_W-1:0]  tags  [SETS];
  logic [LINE_W-1:0] lines [SETS];
  logic [LINE_W-1:0] rd_line;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= '0;
    end else if (fill) begin
      valid[wr_idx] <= 1'b1;
    end else if (inv) begin
      valid[inv_idx] <= 1'b0;
    end
  end

  // Tag and data storage carry no reset; the valid bit alone qualifies them.
  always_ff @(posedge clk) begin
    if (fill) begin
      tags[wr_idx]  <= wr_tag;
      lines[wr_idx] <= wr_line;
    end
  end

  assign rd_line  = lines[rd_idx];
  assign rd_valid = valid[rd_idx];
  assign rd_hit   = rd_valid && (tags[rd_idx] == rd_tag);
  assign rd_word  = rd_line[rd_wsel * INST_W +: INST_W];

endmodule

// File: rtl/icache_sa.sv
// rtl/icache_sa.sv - set-associative instruction cache with round-robin refill and sequential flush; ICACHE_STATS_EN adds hit/miss counters
module icache_sa
  import icache_sa_pkg::*;
#(
  parameter int ADDR_W = 20,
  parameter int INST_W = 32,
  parameter int LINE_W = ICACHE_LINE_W,
  parameter int SETS   = ICACHE_SETS,
  parameter int WAYS   = ICACHE_WAYS
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] addr,
  input  logic              enable,
  input  logic              flush,
  output logic [INST_W-1:0] instr_data,
  output logic              miss,
  output logic              busy,
  icache_sa_if.master       mem
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0]       hit_cnt,
  output logic [31:0]       miss_cnt
`endif
);

  localparam int OFF    = $clog2(LINE_W / 8);
  localparam int IDX_W  = $clog2(SETS);
  localparam int TAG_W  = ADDR_W - IDX_W - OFF;
  localparam int BOFF   = $clog2(INST_W / 8);
  localparam int WSEL_W = $clog2(LINE_W / INST_W);
  localparam int RR_W   = (WAYS > 1) ? $clog2(WAYS) : 1;

  if (TAG_W < 1) begin : g_tag_check
    $error("icache_sa: ADDR_W leaves no tag bits for this SETS/LINE_W");
  end

  icache_state_t     state, state_n;
  logic [ADDR_W-1:0] addr_buf;
  logic              flush_pending;
  logic [IDX_W-1:0]  flush_cnt;
  logic [RR_W-1:0]   rr [SETS];

  logic [IDX_W-1:0]  rd_idx, buf_idx;
  logic [TAG_W-1:0]  rd_tag, buf_tag;
  logic [WAYS-1:0]   hit_vec, valid_vec, fill_vec;
  logic [INST_W-1:0] word_vec [WAYS];
  logic              hit, all_valid;
  logic [INST_W-1:0] hit_word;
  logic [RR_W-1:0]   victim;
  logic              fill, inv, latch, set_pend, clr_pend, hit_evt, mem_req_c;
  logic              unused_bits;

  assign buf_idx = addr_buf[OFF +: IDX_W];
  assign buf_tag = addr_buf[ADDR_W-1 -: TAG_W];
  assign rd_tag  = addr[ADDR_W-1 -: TAG_W];
  // While refilling, the read port watches the buffered set so victim choice sees its valid bits.
  assign rd_idx  = (state == REFILL) ? buf_idx : addr[OFF +: IDX_W];

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    assign fill_vec[w] = fill && (victim == RR_W'(w));
    icache_way #(
      .INST_W (INST_W),
      .LINE_W (LINE_W),
      .SETS   (SETS),
      .TAG_W  (TAG_W)
    ) u_way (
      .clk      (clk),
      .rst_n    (rst_n),
      .rd_idx   (rd_idx),
      .rd_tag   (rd_tag),
      .rd_wsel  (addr[BOFF +: WSEL_W]),
      .rd_valid (valid_vec[w]),
      .rd_hit   (hit_vec[w]),
      .rd_word  (word_vec[w]),
      .fill     (fill_vec[w]),
      .wr_idx   (buf_idx),
      .wr_tag   (buf_tag),
      .wr_line  (mem.mem_data),
      .inv      (inv),
      .inv_idx  (flush_cnt)
    );
  end

  always_comb begin
    hit      = 1'b0;
    hit_word = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (hit_vec[w]) begin
        hit      = 1'b1;
        hit_word = word_vec[w];
      end
    end
  end

  always_comb begin
    all_valid = &valid_vec;
    victim    = rr[buf_idx];
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_vec[w]) victim = RR_W'(w);
    end
  end

  always_comb begin
    state_n   = state;
    miss      = 1'b0;
    mem_req_c = 1'b0;
    fill      = 1'b0;
    inv       = 1'b0;
    latch     = 1'b0;
    set_pend  = 1'b0;
    clr_pend  = 1'b0;
    hit_evt   = 1'b0;
    unique case (state)
      IDLE: begin
        if (flush || flush_pending) begin
          state_n  = FLUSH;
          miss     = 1'b1;
          clr_pend = 1'b1;
        end else if (enable && hit) begin
          hit_evt = 1'b1;
        end else if (enable) begin
          miss    = 1'b1;
          latch   = 1'b1;
          state_n = REFILL;
        end
      end
      REFILL: begin
        miss      = 1'b1;
        mem_req_c = 1'b1;
        set_pend  = flush;
        if (mem.mem_rdy) begin
          fill    = 1'b1;
          state_n = IDLE;
        end
      end
      FLUSH: begin
        miss = 1'b1;
        inv  = 1'b1;
        if (flush_cnt == IDX_W'(SETS - 1)) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      addr_buf      <= '0;
      flush_pending <= 1'b0;
      flush_cnt     <= '0;
      for (int s = 0; s < SETS; s++) rr[s] <= '0;
    end else begin
      state <= state_n;
      if (latch) addr_buf <= addr;
      if (set_pend) flush_pending <= 1'b1;
      else if (clr_pend) flush_pending <= 1'b0;
      // flush_cnt wraps back to zero on the last set, ready for the next flush.
      if (inv) begin
        flush_cnt     <= flush_cnt + IDX_W'(1);
        rr[flush_cnt] <= '0;
      end
      if (fill && all_valid) begin
        rr[buf_idx] <= (rr[buf_idx] == RR_W'(WAYS - 1)) ? '0 : rr[buf_idx] + RR_W'(1);
      end
    end
  end

  assign busy         = (state == FLUSH) || flush_pending;
  assign instr_data   = hit_evt ? hit_word : '0;
  assign mem.mem_req  = mem_req_c;
  assign mem.mem_addr = {addr_buf[ADDR_W-1:OFF], {OFF{1'b0}}};
  assign unused_bits  = ^{1'b0, addr, addr_buf};

  a_single_hit: assert property (@(posedge clk) disable iff (!rst_n)
    !((state == IDLE) && enable && !$onehot0(hit_vec)));

`ifdef ICACHE_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      if (hit_evt && (hit_cnt != '1)) hit_cnt <= hit_cnt + 32'd1;
      if (latch && (miss_cnt != '1)) miss_cnt <= miss_cnt + 32'd1;
    end
  end
`endif

endmodule
